// File: rtl/hs_pkg.sv
// Shared types and default sizes for the req/ack byte transmitter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package hs_pkg;

    // Default configuration of the transmitter.
    localparam int HS_DATA_W      = 8;
    localparam int HS_DEPTH       = 4;
    localparam int HS_SYNC_STAGES = 2;
    localparam int HS_TIMEOUT_CYC = 1000;

    // Handshake sequencer states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2,
        WAIT_REL = 2'd3
    } hs_state_t;

endpackage

// File: rtl/hs_ack_sync.sv
// Brings the MCU acknowledge into the clk domain through a plain flop chain.
// Latency: SYNC_STAGES clk cycles from ack_async to ack_s.
// Backpressure: none; samples every cycle.
module hs_ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ack_async,
    output logic ack_s
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the asynchronous level through the chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], ack_async};
        end
    end

    assign ack_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/hs_byte_tx.sv
// Queues bytes in a small FIFO and sends each over a 4-phase req/ack link (optional ack timeout: HS_TIMEOUT_EN).
// Latency: word offered in the cycle after edge N -> data_out after edge N+2, req_out after edge N+3.
// Backpressure: in_ready drops while the FIFO is full; the link waits on ack (or the timeout when enabled).
module hs_byte_tx
    import hs_pkg::*;
#(
    parameter int DATA_W      = HS_DATA_W,
    parameter int DEPTH       = HS_DEPTH,
    parameter int SYNC_STAGES = HS_SYNC_STAGES,
    parameter int TIMEOUT_CYC = HS_TIMEOUT_CYC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        data_out,
    output logic                     req_out,
    input  logic                     ack_async,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic              ack_s;
    logic              req_set;
    logic              req_clr;
    logic              tmo_expired;
    hs_state_t         state;
    hs_state_t         state_nxt;

    hs_ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk       (clk),
        .reset     (reset),
        .ack_async (ack_async),
        .ack_s     (ack_s)
    );

    // A full FIFO ignores in_valid; a word pushed and popped together leaves count as is.
    assign in_ready   = (count < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);

    // Storage: write-only port here, the head is read when a word is launched.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef HS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    // Per-phase watchdog: restarts on every state change, runs while waiting on the MCU.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state_nxt != state) begin
            tmo_cnt <= '0;
        end else if ((state == WAIT_ACK) || (state == WAIT_REL)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign tmo_expired = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // A timeout only counts when the MCU did not answer in that same cycle.
    assign tmo_hit = tmo_expired &&
                     (((state == WAIT_ACK) && !ack_s) || ((state == WAIT_REL) && ack_s));

    // Sticky error: once the MCU has missed a phase, only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (tmo_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_expired = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake controls; a timed-out word is dropped, never retried.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        req_set   = 1'b0;
        req_clr   = 1'b0;
        case (state)
            IDLE: begin
                // A stale ack from the previous word must be released before loading.
                if ((count != '0) && !ack_s) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                // data_out has been stable for a full cycle when req rises.
                req_set   = 1'b1;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_s) begin
                    req_clr   = 1'b1;
                    state_nxt = WAIT_REL;
                end else if (tmo_expired) begin
                    req_clr   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_REL: begin
                if (!ack_s || tmo_expired) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Link outputs are registered; data_out holds until the next word is launched.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            req_out  <= 1'b0;
        end else begin
            if (pop) begin
                data_out <= mem[rd_ptr];
            end
            if (req_set) begin
                req_out <= 1'b1;
            end else if (req_clr) begin
                req_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hs_byte_tx.sv
// Self-checking bench for hs_byte_tx with a scoreboard of queued words and an MCU responder model.
// Latency: checks launch timing relative to the push edge.
// Backpressure: exercises FIFO full, stale ack, reset abort, ack glitches and (HS_TIMEOUT_EN) timeouts.
module tb_hs_byte_tx;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 16;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] data_out;
    logic              req_out;
    logic              ack_async;
    logic              busy;
    logic [2:0]        fifo_count;
    logic              timeout_err;

    logic              mcu_en;
    logic              ack_mcu;
    logic              ack_man;
    int                mcu_dly;
    logic              req_prev;

    int                n_tests;
    int                n_fail;
    int                n_xfer;
    int                xfer_base;
    logic [DATA_W-1:0] exp_q [$];

    assign ack_async = mcu_en ? ack_mcu : ack_man;

    hs_byte_tx #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .data_out    (data_out),
        .req_out     (req_out),
        .ack_async   (ack_async),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge, then settle 1 ns so inputs change and outputs are read away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            step();
            if (!busy && !ack_async) break;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_req(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (req_out) break;
            step();
        end
        check(tag, 32'(req_out), 32'd1);
    endtask

    // Scoreboard: every rising req must present the oldest still-expected word.
    always @(negedge clk) begin
        if (req_out && !req_prev) begin
            n_xfer++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
        req_prev = req_out;
    end

    // MCU model: follows req with a 3-cycle delay in each direction.
    initial begin
        ack_mcu = 1'b0;
        mcu_dly = 0;
        forever begin
            @(negedge clk);
            if (!mcu_en) begin
                ack_mcu = 1'b0;
                mcu_dly = 0;
            end else if (req_out != ack_mcu) begin
                mcu_dly++;
                if (mcu_dly >= 3) begin
                    ack_mcu = req_out;
                    mcu_dly = 0;
                end
            end else begin
                mcu_dly = 0;
            end
        end
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        n_xfer   = 0;
        req_prev = 1'b0;
        mcu_en   = 1'b0;
        ack_man  = 1'b0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state.
        check("rst_req", 32'(req_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);

        // 1: single word, full 4-phase cycle. Word offered after edge N, sampled at N+1.
        mcu_en    = 1'b1;
        xfer_base = n_xfer;
        step();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        step();
        in_valid = 1'b0;
        check("t1_count_n1", 32'(fifo_count), 32'd1);
        check("t1_data_n1", 32'(data_out), 32'd0);
        step();
        check("t1_data_n2", 32'(data_out), 32'hA5);
        check("t1_req_n2", 32'(req_out), 32'd0);
        check("t1_count_n2", 32'(fifo_count), 32'd0);
        step();
        check("t1_req_n3", 32'(req_out), 32'd1);
        wait_idle("t1_idle", 60);
        check("t1_xfers", 32'(n_xfer - xfer_base), 32'd1);
        check("t1_req_end", 32'(req_out), 32'd0);
        check("t1_data_hold", 32'(data_out), 32'hA5);

        // 2: five words back to back with ack held low; fifth fills the FIFO.
        mcu_en    = 1'b0;
        ack_man   = 1'b0;
        xfer_base = n_xfer;
        for (int i = 1; i <= 5; i++) begin
            check("t2_ready_push", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = 8'(i);
            exp_q.push_back(8'(i));
            step();
        end
        check("t2_ready_full", 32'(in_ready), 32'd0);
        check("t2_count_full", 32'(fifo_count), 32'd4);
        in_data = 8'h66;
        step();
        in_valid = 1'b0;
        check("t2_count_ignored", 32'(fifo_count), 32'd4);
        check("t2_req_held", 32'(req_out), 32'd1);
        mcu_en = 1'b1;
        wait_idle("t2_idle", 400);
        check("t2_xfers", 32'(n_xfer - xfer_base), 32'd5);
        check("t2_sb_drained", 32'(exp_q.size()), 32'd0);
`ifndef HS_TIMEOUT_EN
        check("t2_terr_tied", 32'(timeout_err), 32'd0);
`endif

        // 3: ack already high at reset release; no load until it drops.
        mcu_en  = 1'b0;
        ack_man = 1'b1;
        reset   = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
        repeat (3) step();
        xfer_base = n_xfer;
        in_valid  = 1'b1;
        in_data   = 8'hB7;
        exp_q.push_back(8'hB7);
        step();
        in_valid = 1'b0;
        repeat (8) step();
        check("t3_hold_count", 32'(fifo_count), 32'd1);
        check("t3_hold_data", 32'(data_out), 32'd0);
        check("t3_hold_req", 32'(req_out), 32'd0);
        ack_man = 1'b0;
        wait_req("t3_req", 20);
        mcu_en = 1'b1;
        wait_idle("t3_idle", 60);
        check("t3_xfers", 32'(n_xfer - xfer_base), 32'd1);

        // 4: reset in WAIT_ACK with two words still queued.
        mcu_en  = 1'b0;
        ack_man = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hC1 + 8'(i);
            exp_q.push_back(8'hC1 + 8'(i));
            step();
        end
        in_valid = 1'b0;
        wait_req("t4_req", 20);
        step();
        check("t4_count_pre", 32'(fifo_count), 32'd2);
        reset = 1'b1;
        step();
        check("t4_req_abort", 32'(req_out), 32'd0);
        check("t4_count_abort", 32'(fifo_count), 32'd0);
        check("t4_busy_abort", 32'(busy), 32'd0);
        check("t4_data_abort", 32'(data_out), 32'd0);
        reset = 1'b0;
        exp_q.delete();

        // 6: sub-cycle ack glitches during WAIT_ACK must not advance the handshake.
        xfer_base = n_xfer;
        in_valid  = 1'b1;
        in_data   = 8'hD4;
        exp_q.push_back(8'hD4);
        step();
        in_valid = 1'b0;
        wait_req("t6_req", 20);
        for (int i = 0; i < 4; i++) begin
            #2 ack_man = 1'b1;
            #3 ack_man = 1'b0;
            step();
        end
        repeat (3) step();
        check("t6_req_glitch", 32'(req_out), 32'd1);
        check("t6_busy_glitch", 32'(busy), 32'd1);
        mcu_en = 1'b1;
        wait_idle("t6_idle", 60);
        check("t6_xfers", 32'(n_xfer - xfer_base), 32'd1);

`ifdef HS_TIMEOUT_EN
        // 5: never ack; req falls 16 edges after WAIT_ACK entry, error sticks, next word goes out.
        mcu_en  = 1'b0;
        ack_man = 1'b0;
        reset   = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        xfer_base = n_xfer;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hE1 + 8'(i);
            exp_q.push_back(8'hE1 + 8'(i));
            step();
        end
        in_valid = 1'b0;
        wait_req("t5_req", 20);
        repeat (15) step();
        check("t5_req_before", 32'(req_out), 32'd1);
        check("t5_terr_before", 32'(timeout_err), 32'd0);
        step();
        check("t5_req_timeout", 32'(req_out), 32'd0);
        check("t5_terr_set", 32'(timeout_err), 32'd1);
        step();
        wait_req("t5_next_req", 20);
        wait_idle("t5_idle", 60);
        check("t5_terr_sticky", 32'(timeout_err), 32'd1);
        check("t5_xfers", 32'(n_xfer - xfer_base), 32'd2);
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
